// File: rtl/key_mux_pkg.sv
// Shared types and constants for the key-half round-robin arbiter.
// Also holds a small one-hot decode helper used by the top level.
package key_mux_pkg;

  localparam int         KEY_W   = 28;
  localparam logic [1:0] PTR_RST = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/key_mux_arbiter_rr_pick4.sv
// Combinational rotating-priority encoder: first set bit of elig scanning
// ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4 (
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  // Walk the scan order backwards so the earliest candidate is written last.
  always_comb begin
    logic [1:0] idx_s;
    win   = ptr;
    any   = 1'b0;
    idx_s = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx_s = ptr + k[1:0];
      win   = elig[idx_s] ? idx_s : win;
      any   = any | elig[idx_s];
    end
  end

endmodule

// File: rtl/key_mux_arbiter.sv
// Round-robin 4:1 key-half mux with a single registered valid/ready output stage.
// Optional locked mode is enabled by defining KEY_MUX_ARB_LOCK_EN.
module key_mux_arbiter
  import key_mux_pkg::*;
#(
  parameter int WIDTH = KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] k0,
  input  logic [WIDTH-1:0] k1,
  input  logic [WIDTH-1:0] k2,
  input  logic [WIDTH-1:0] k3,
`ifdef KEY_MUX_ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  input  logic             y_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
);

  state_e           state_r, state_nxt_s;
  logic [1:0]       ptr_r, sel_r, win_s;
  logic [3:0]       gnt_r, elig_s;
  logic [WIDTH-1:0] y_r, data_s;
  logic             any_s, ld_s;

`ifdef KEY_MUX_ARB_LOCK_EN
  logic             locked_r;
  logic [1:0]       lock_idx_r;

  // Eligible set: grant mask, narrowed to the locked requester when locked.
  always_comb begin
    if (locked_r) begin
      elig_s = req & ~gnt_r & onehot4(lock_idx_r);
    end else begin
      elig_s = req & ~gnt_r;
    end
  end

  // Locked-mode tracking; while locked the winner is always lock_idx_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_r   <= 1'b0;
      lock_idx_r <= 2'd0;
    end else if (ld_s) begin
      locked_r   <= lock[win_s];
      lock_idx_r <= win_s;
    end
  end
`else
  assign elig_s = req & ~gnt_r;
`endif

  rr_pick4 u_pick (
    .elig (elig_s),
    .ptr  (ptr_r),
    .win  (win_s),
    .any  (any_s)
  );

  assign ld_s = any_s && ((state_r == ST_IDLE) || y_ready);

  // Data select for the winning requester.
  always_comb begin
    case (win_s)
      2'd0:    data_s = k0;
      2'd1:    data_s = k1;
      2'd2:    data_s = k2;
      2'd3:    data_s = k3;
      default: data_s = '0;
    endcase
  end

  // Next state: a stalled HOLD keeps its word; an accepted word with nothing pending drains to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_s) state_nxt_s = ST_HOLD;
        else      state_nxt_s = ST_IDLE;
      end
      ST_HOLD: begin
        if (y_ready && !ld_s) state_nxt_s = ST_IDLE;
        else                  state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, output word, pointer and grant pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      y_r     <= '0;
      sel_r   <= 2'd0;
      ptr_r   <= PTR_RST;
      gnt_r   <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      if (ld_s) begin
        y_r   <= data_s;
        sel_r <= win_s;
        ptr_r <= win_s;
        gnt_r <= onehot4(win_s);
      end else begin
        gnt_r <= 4'b0000;
      end
    end
  end

  assign gnt     = gnt_r;
  assign sel     = sel_r;
  assign y       = y_r;
  assign y_valid = (state_r == ST_HOLD);
  assign busy    = y_valid || (req != 4'b0000);

endmodule

// File: tb/tb_key_mux_arbiter.sv
// Self-checking bench for key_mux_arbiter: directed vector table, reset corner
// sequence and randomized traffic against a rule-level reference model.
module tb_key_mux_arbiter;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] k0, k1, k2, k3;
  logic         y_ready;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic         y_valid, busy;
`ifdef KEY_MUX_ARB_LOCK_EN
  logic [3:0]   lock = 4'b0000;
`endif

  always #5 clk = ~clk;

  key_mux_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .k0(k0), .k1(k1), .k2(k2), .k3(k3),
`ifdef KEY_MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .y_ready(y_ready), .gnt(gnt), .sel(sel), .y(y),
    .y_valid(y_valid), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_y;
  logic [1:0]   m_sel, m_ptr;
  logic [3:0]   m_gnt;
  logic         m_valid;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_y = '0; m_sel = 2'd0; m_ptr = 2'd3; m_gnt = 4'b0000; m_valid = 1'b0;
  endtask

  // Apply the arbitration rules to the inputs present at the clock edge.
  task automatic model_step();
    logic [3:0]   e;
    logic [W-1:0] kk [4];
    int           w;
    bit           found;
    kk[0] = k0; kk[1] = k1; kk[2] = k2; kk[3] = k3;
    e = req & ~m_gnt;
    found = 1'b0;
    w = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && e[(int'(m_ptr) + i) % 4]) begin
        found = 1'b1;
        w = (int'(m_ptr) + i) % 4;
      end
    end
    if (found && (!m_valid || y_ready)) begin
      m_y = kk[w]; m_sel = w[1:0]; m_ptr = w[1:0];
      m_gnt = 4'b0001 << w; m_valid = 1'b1;
    end else begin
      m_gnt = 4'b0000;
      if (y_ready) m_valid = 1'b0;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".y"},       y,       m_y);
    chk({tag, ".sel"},     sel,     m_sel);
    chk({tag, ".gnt"},     gnt,     m_gnt);
    chk({tag, ".y_valid"}, y_valid, m_valid);
    chk({tag, ".busy"},    busy,    m_valid || (req != 4'b0000));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model(tag);
  endtask

  typedef struct {
    logic [3:0]   req;
    logic         yr;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         v;
    logic [W-1:0] y;
  } vec_t;

  localparam logic [W-1:0] K0 = 28'h0ABCDEF;
  localparam logic [W-1:0] K1 = 28'h1111111;
  localparam logic [W-1:0] K2 = 28'h2222222;
  localparam logic [W-1:0] K3 = 28'h3333333;

  vec_t tbl [22];

  initial begin
    // Round-robin sweep from reset
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, K0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, K1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, K2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, K3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, K0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, K0};
    // Single request, then drop
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, K0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, K0};
    // Load k3 with no ready, then stall five cycles with 0110 pending
    tbl[8]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, K3};
    tbl[9]  = '{4'b0110, 1'b0, 4'b0000, 2'd3, 1'b1, K3};
    tbl[10] = '{4'b0110, 1'b0, 4'b0000, 2'd3, 1'b1, K3};
    tbl[11] = '{4'b0110, 1'b0, 4'b0000, 2'd3, 1'b1, K3};
    tbl[12] = '{4'b0110, 1'b0, 4'b0000, 2'd3, 1'b1, K3};
    tbl[13] = '{4'b0110, 1'b0, 4'b0000, 2'd3, 1'b1, K3};
    tbl[14] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, K1};
    tbl[15] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, K2};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, K2};
    // Lone requester 2: grant mask forces every-other-cycle capture
    tbl[17] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, K2};
    tbl[18] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, K2};
    tbl[19] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, K2};
    tbl[20] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, K2};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, K2};

    rst_n = 1'b0; req = 4'b0000; y_ready = 1'b0;
    k0 = K0; k1 = K1; k2 = K2; k3 = K3;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset.y", y, '0);
    chk("reset.sel", sel, 2'd0);
    chk("reset.gnt", gnt, 4'b0000);
    chk("reset.y_valid", y_valid, 1'b0);
    chk("reset.busy", busy, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      req = tbl[i].req;
      y_ready = tbl[i].yr;
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.gnt_const", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d.sel_const", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d.valid_const", i), y_valid, tbl[i].v);
      chk($sformatf("tbl%0d.y_const", i), y, tbl[i].y);
    end

    // Reset while a word is held in a stalled HOLD
    req = 4'b0001; y_ready = 1'b0;
    cycle("pre_rst");
    chk("pre_rst.y_valid", y_valid, 1'b1);
    req = 4'b0000;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst.y", y, '0);
    chk("mid_rst.y_valid", y_valid, 1'b0);
    chk("mid_rst.gnt", gnt, 4'b0000);
    chk("mid_rst.sel", sel, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000; y_ready = 1'b1;
    cycle("post_rst3");
    chk("post_rst3.sel_const", sel, 2'd3);
    chk("post_rst3.gnt_const", gnt, 4'b1000);
    req = 4'b0001;
    cycle("post_rst0");
    chk("post_rst0.sel_const", sel, 2'd0);
    chk("post_rst0.gnt_const", gnt, 4'b0001);
    req = 4'b0000;
    cycle("post_rst_idle");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      req     = 4'($urandom_range(0, 15));
      y_ready = ($urandom_range(0, 3) != 0);
      k0 = W'($urandom); k1 = W'($urandom);
      k2 = W'($urandom); k3 = W'($urandom);
      cycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
